// File: rtl/cache_controller.sv
// cache_controller
//   Direct-mapped, write-through, no-write-allocate cache between the CPU
//   load/store stage and a data memory that returns 4-word blocks.
//   Read hits are served from the local tag/data arrays. A read miss issues
//   a block read, waits for memReady, and refills one line. Writes always go
//   to memory and update the cache only when the line is already present.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cpuRead, cpuWrite        CPU requests (sampled in IDLE, read has priority)
//   cpuAddress, cpuWriteData CPU word address and store data
//   cpuReadData, cpuReady    load data and one-cycle completion pulse
//   hit                      set with cpuReady when the completed read hit
//   memRead, memWrite        block-read request / single-word write strobe
//   memAddress               word address of the write or critical word
//   memAddress0..3           word addresses of the line being filled
//   memWriteData             store data to memory
//   block0..3, memReady      refill words and their valid level
//   accessCount, hitCount    completed accesses / completed read hits
module cache_controller #(
  parameter int WORD     = 32,
  parameter int ADDRESSL = 15,
  parameter int OFFSETL  = 2,
  parameter int INDEXL   = 10,
  parameter int CNTW     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpuRead,
  input  logic                cpuWrite,
  input  logic [ADDRESSL-1:0] cpuAddress,
  input  logic [WORD-1:0]     cpuWriteData,
  output logic [WORD-1:0]     cpuReadData,
  output logic                cpuReady,
  output logic                hit,
  output logic                memRead,
  output logic                memWrite,
  output logic [ADDRESSL-1:0] memAddress,
  output logic [ADDRESSL-1:0] memAddress0,
  output logic [ADDRESSL-1:0] memAddress1,
  output logic [ADDRESSL-1:0] memAddress2,
  output logic [ADDRESSL-1:0] memAddress3,
  output logic [WORD-1:0]     memWriteData,
  input  logic [WORD-1:0]     block0,
  input  logic [WORD-1:0]     block1,
  input  logic [WORD-1:0]     block2,
  input  logic [WORD-1:0]     block3,
  input  logic                memReady,
  output logic [CNTW-1:0]     accessCount,
  output logic [CNTW-1:0]     hitCount
);

  localparam int TAGL  = ADDRESSL - INDEXL - OFFSETL;
  localparam int LINES = 1 << INDEXL;
  localparam int WORDS = 1 << OFFSETL;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, DONE} state_t;

  state_t state, next_state;

  logic [ADDRESSL-1:0] addr;
  logic [OFFSETL-1:0]  addr_offset;
  logic [INDEXL-1:0]   addr_index;
  logic [TAGL-1:0]     addr_tag;
  logic [LINES-1:0]    valid;
  logic [TAGL-1:0]     tag_mem [LINES];
  logic [WORD-1:0]     refill [WORDS];
  logic [WORD-1:0]     line_word [WORDS];
  logic                line_hit;
  logic                fill_write;
  logic                store_write;
  logic                accept;

  assign addr_offset = addr[OFFSETL-1:0];
  assign addr_index  = addr[OFFSETL +: INDEXL];
  assign addr_tag    = addr[ADDRESSL-1 -: TAGL];

  assign refill[0] = block0;
  assign refill[1] = block1;
  assign refill[2] = block2;
  assign refill[3] = block3;

  assign line_hit    = valid[addr_index] && (tag_mem[addr_index] == addr_tag);
  assign fill_write  = (state == FILL) && memReady;
  assign store_write = (state == WRITE) && line_hit;
  assign accept      = (state == IDLE) && (cpuRead || cpuWrite);

  // One bank per word offset so a refill writes all four words of the line
  // in the same cycle while a store touches only its own bank.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_bank
      logic [WORD-1:0] bank [LINES];

      always_ff @(posedge clk) begin
        if (fill_write) begin
          bank[addr_index] <= refill[gi];
        end else if (store_write && (addr_offset == OFFSETL'(gi))) begin
          bank[addr_index] <= memWriteData;
        end
      end

      assign line_word[gi] = bank[addr_index];
    end
  endgenerate

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      tag_mem[addr_index] <= addr_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_write) begin
      valid[addr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cpuRead) begin
          next_state = LOOKUP;
        end else if (cpuWrite) begin
          next_state = WRITE;
        end
      end
      LOOKUP:  next_state = line_hit ? DONE : FILL;
      FILL:    next_state = memReady ? DONE : FILL;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs. memRead/memWrite follow the state being entered so
  // they are high exactly while the FSM sits in FILL / WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr         <= '0;
      cpuReadData  <= '0;
      cpuReady     <= 1'b0;
      hit          <= 1'b0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      memAddress   <= '0;
      memAddress0  <= '0;
      memAddress1  <= '0;
      memAddress2  <= '0;
      memAddress3  <= '0;
      memWriteData <= '0;
      accessCount  <= '0;
      hitCount     <= '0;
    end else begin
      cpuReady <= (state == DONE);
      memRead  <= (next_state == FILL);
      memWrite <= (next_state == WRITE);

      if (accept) begin
        addr        <= cpuAddress;
        memAddress  <= cpuAddress;
        memAddress0 <= {cpuAddress[ADDRESSL-1:OFFSETL], OFFSETL'(0)};
        memAddress1 <= {cpuAddress[ADDRESSL-1:OFFSETL], OFFSETL'(1)};
        memAddress2 <= {cpuAddress[ADDRESSL-1:OFFSETL], OFFSETL'(2)};
        memAddress3 <= {cpuAddress[ADDRESSL-1:OFFSETL], OFFSETL'(3)};
        hit         <= 1'b0;
        // A simultaneous read wins, so store data is only taken for writes.
        if (!cpuRead) begin
          memWriteData <= cpuWriteData;
        end
      end

      case (state)
        LOOKUP: begin
          if (line_hit) begin
            cpuReadData <= line_word[addr_offset];
            hit         <= 1'b1;
            hitCount    <= hitCount + CNTW'(1);
            accessCount <= accessCount + CNTW'(1);
          end
        end
        FILL: begin
          if (memReady) begin
            cpuReadData <= refill[addr_offset];
            accessCount <= accessCount + CNTW'(1);
          end
        end
        WRITE: begin
          accessCount <= accessCount + CNTW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller. The reference model keeps
// a flat memory image plus a per-line {valid, tag} directory; expected load
// data always comes from the memory image because the cache is write-through.
module tb_cache_controller;

  localparam int WORD     = 32;
  localparam int ADDRESSL = 15;
  localparam int MEMW     = 1 << ADDRESSL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                cpuRead = 1'b0;
  logic                cpuWrite = 1'b0;
  logic [ADDRESSL-1:0] cpuAddress = '0;
  logic [WORD-1:0]     cpuWriteData = '0;
  logic [WORD-1:0]     cpuReadData;
  logic                cpuReady;
  logic                hit;
  logic                memRead;
  logic                memWrite;
  logic [ADDRESSL-1:0] memAddress;
  logic [ADDRESSL-1:0] memAddress0;
  logic [ADDRESSL-1:0] memAddress1;
  logic [ADDRESSL-1:0] memAddress2;
  logic [ADDRESSL-1:0] memAddress3;
  logic [WORD-1:0]     memWriteData;
  logic [WORD-1:0]     block0 = '0;
  logic [WORD-1:0]     block1 = '0;
  logic [WORD-1:0]     block2 = '0;
  logic [WORD-1:0]     block3 = '0;
  logic                memReady = 1'b0;
  logic [31:0]         accessCount;
  logic [31:0]         hitCount;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpuRead(cpuRead), .cpuWrite(cpuWrite),
    .cpuAddress(cpuAddress), .cpuWriteData(cpuWriteData),
    .cpuReadData(cpuReadData), .cpuReady(cpuReady), .hit(hit),
    .memRead(memRead), .memWrite(memWrite), .memAddress(memAddress),
    .memAddress0(memAddress0), .memAddress1(memAddress1),
    .memAddress2(memAddress2), .memAddress3(memAddress3),
    .memWriteData(memWriteData),
    .block0(block0), .block1(block1), .block2(block2), .block3(block3),
    .memReady(memReady),
    .accessCount(accessCount), .hitCount(hitCount)
  );

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    bit          is_read;
    logic [14:0] addr;
    logic [31:0] data;
    bit          exp_hit;
    logic [31:0] acc;
    logic [31:0] hits;
    int          accept;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // Reference model
  logic [31:0] ref_mem [MEMW];
  bit          ref_valid [1024];
  logic [2:0]  ref_tag [1024];
  logic [31:0] ref_acc = 0;
  logic [31:0] ref_hits = 0;

  // Memory model seen by the DUT
  logic [31:0] tb_mem [MEMW];

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [14:0] cur_addr = '0;
  logic [31:0] cur_data = '0;
  bit          hold_mem = 1'b0;
  int          wait_cnt = 0;

  // Memory responder: random refill delay, optional indefinite hold.
  always @(negedge clk) begin
    if (memWrite && !rst) begin
      tb_mem[memAddress] = memWriteData;
    end
    if (memRead && !rst && !hold_mem) begin
      if (wait_cnt == 0) begin
        if (!memReady) begin
          check("line_addr0", memAddress0, {cur_addr[14:2], 2'd0});
          check("line_addr3", memAddress3, {cur_addr[14:2], 2'd3});
          check("crit_addr", memAddress, cur_addr);
        end
        block0   = tb_mem[memAddress0];
        block1   = tb_mem[memAddress1];
        block2   = tb_mem[memAddress2];
        block3   = tb_mem[memAddress3];
        memReady = 1'b1;
      end else begin
        wait_cnt--;
      end
    end else begin
      memReady = 1'b0;
      wait_cnt = $urandom_range(0, 4);
    end
  end

  // Monitor: pops one expectation per cpuReady pulse.
  int   rd_cyc = 0;
  int   wr_cyc = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      rd_cyc = 0;
      wr_cyc = 0;
    end else if (cpuReady) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_read) begin
          check("rd_data", cpuReadData, mon_e.data);
          check(mon_e.exp_hit ? "hit_memread_cycles" : "miss_memread_seen",
                mon_e.exp_hit ? 64'(rd_cyc) : 64'(rd_cyc > 0), mon_e.exp_hit ? 0 : 1);
        end
        check("hit", hit, mon_e.exp_hit);
        check("access_count", accessCount, mon_e.acc);
        check("hit_count", hitCount, mon_e.hits);
        check("memwrite_cycles", wr_cyc, mon_e.is_read ? 0 : 1);
        if (mon_e.lat > 0) check("latency", cyc - mon_e.accept, mon_e.lat);
        $display("[TB] %s addr=%04h data=%08h hit=%0d acc=%0d hits=%0d",
                 mon_e.is_read ? "RD" : "WR", mon_e.addr, cpuReadData, hit,
                 accessCount, hitCount);
      end
      rd_cyc = 0;
      wr_cyc = 0;
    end else begin
      if (memRead) rd_cyc++;
      if (memWrite) begin
        wr_cyc++;
        check("wr_addr", memAddress, cur_addr);
        check("wr_data", memWriteData, cur_data);
      end
      if (memRead && memWrite) check("rd_wr_exclusive", 1, 0);
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [14:0] a,
                        input logic [31:0] d);
    exp_t e;
    int   n;
    logic [9:0] idx;
    @(negedge clk);
    idx       = a[11:2];
    e.is_read = rd;
    e.addr    = a;
    e.accept  = cyc + 1;
    if (rd) begin
      e.exp_hit = ref_valid[idx] && (ref_tag[idx] == a[14:12]);
      e.data    = ref_mem[a];
      ref_acc++;
      if (e.exp_hit) ref_hits++;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[14:12];
      e.lat = e.exp_hit ? 2 : 0;
    end else begin
      e.exp_hit  = 1'b0;
      e.data     = '0;
      ref_mem[a] = d;
      ref_acc++;
      e.lat = 2;
    end
    e.acc  = ref_acc;
    e.hits = ref_hits;
    sb.push_back(e);
    cur_addr     = a;
    cur_data     = d;
    cpuRead      = rd;
    cpuWrite     = wr;
    cpuAddress   = a;
    cpuWriteData = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpuReady && n < 400);
    if (!cpuReady) begin
      check("ready_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    cpuRead  = 1'b0;
    cpuWrite = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < MEMW; i++) begin
      ref_mem[i] = i;
      tb_mem[i]  = i;
    end
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_outputs", {cpuReady, hit, memRead, memWrite}, 0);
    check("rst_addrs", {memAddress, memAddress0, memAddress3}, 0);
    check("rst_data", {cpuReadData, memWriteData}, 0);
    check("rst_counts", {accessCount, hitCount}, 0);
    rst = 1'b0;

    // Directed sequence
    access(1, 0, 15'h0005, 0);
    access(1, 0, 15'h0006, 0);
    access(1, 0, 15'h1005, 0);
    access(1, 0, 15'h0005, 0);
    access(0, 1, 15'h0006, 32'hDEADBEEF);
    access(1, 0, 15'h0006, 0);
    access(0, 1, 15'h2000, 32'h12345678);
    access(1, 0, 15'h2000, 0);
    access(1, 1, 15'h0010, 32'hCAFEF00D);
    access(1, 0, 15'h0010, 0);

    // Randomized traffic over a small footprint to mix hits, misses, conflicts
    for (int t = 0; t < 150; t++) begin
      int          kind;
      logic [14:0] a;
      kind = $urandom_range(0, 9);
      a = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (kind < 6)      access(1, 0, a, 0);
      else if (kind < 9) access(0, 1, a, $urandom);
      else               access(1, 1, a, $urandom);
    end

    // Reset while a refill is outstanding
    hold_mem = 1'b1;
    @(negedge clk);
    cur_addr   = 15'h0030;
    cpuAddress = 15'h0030;
    cpuRead    = 1'b1;
    n = 0;
    while (!memRead && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fill_memread", memRead, 1);
    cpuRead = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midfill_memread", memRead, 0);
    check("midfill_outputs", {cpuReady, hit, memWrite, memAddress, memAddress0}, 0);
    check("midfill_counts", {accessCount, hitCount, cpuReadData}, 0);
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
    ref_acc  = 0;
    ref_hits = 0;
    @(negedge clk);
    rst      = 1'b0;
    hold_mem = 1'b0;
    access(1, 0, 15'h0030, 0);
    access(1, 0, 15'h0030, 0);
    access(1, 0, 15'h0005, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
